// File: rtl/fft_pkg.sv
// Shared FFT datapath types: Q1.15 packed complex word, field helpers and
// the saturate-to-16 function used on every arithmetic write-back.
package fft_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CPLX_W = 32;
    localparam int unsigned Q      = 15;

    typedef struct packed {
        logic signed [DATA_W-1:0] im;
        logic signed [DATA_W-1:0] re;
    } cplx_t;

    function automatic logic signed [DATA_W-1:0] cplx_re(input cplx_t c);
        return c.re;
    endfunction

    function automatic logic signed [DATA_W-1:0] cplx_im(input cplx_t c);
        return c.im;
    endfunction

    function automatic cplx_t cplx_pack(input logic signed [DATA_W-1:0] re,
                                        input logic signed [DATA_W-1:0] im);
        cplx_t c;
        c.re = re;
        c.im = im;
        return c;
    endfunction

    // Value fits when every bit from the sign position upward agrees.
    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [CPLX_W+1:0] x);
        if ((&x[CPLX_W+1:DATA_W-1]) || !(|x[CPLX_W+1:DATA_W-1])) begin
            return x[DATA_W-1:0];
        end
        if (x[CPLX_W+1]) begin
            return {1'b1, {(DATA_W-1){1'b0}}};
        end
        return {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/bf_twiddle_rom.sv
// Twiddle ROM: round(32767*cos/sin(2*pi*idx/N)) for idx 0..N/2-1,
// table built at elaboration, one-cycle registered read gated by en.
module bf_twiddle_rom
    import fft_pkg::*;
#(
    parameter int unsigned N     = 64,
    parameter int unsigned LOG2N = 6
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [LOG2N-2:0]         addr,
    output logic signed [DATA_W-1:0] cos,
    output logic signed [DATA_W-1:0] sin
);

    localparam real TwoPi = 6.283185307179586;
    localparam real Amp   = 32767.0;

    // Round half away from zero, matching the usual round() definition.
    function automatic logic signed [DATA_W-1:0] tw_val(input int unsigned idx,
                                                       input bit is_sin);
        real ang;
        real v;
        ang = TwoPi * real'(idx) / real'(N);
        if (is_sin) begin
            v = Amp * $sin(ang);
        end else begin
            v = Amp * $cos(ang);
        end
        if (v >= 0.0) begin
            return DATA_W'($rtoi(v + 0.5));
        end
        return -DATA_W'($rtoi(0.5 - v));
    endfunction

    logic signed [DATA_W-1:0] cos_tab [N/2];
    logic signed [DATA_W-1:0] sin_tab [N/2];

    for (genvar i = 0; i < N/2; i++) begin : g_tab
        localparam logic signed [DATA_W-1:0] CosV = tw_val(i, 1'b0);
        localparam logic signed [DATA_W-1:0] SinV = tw_val(i, 1'b1);
        assign cos_tab[i] = CosV;
        assign sin_tab[i] = SinV;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            cos <= cos_tab[addr];
            sin <= sin_tab[addr];
        end
    end

endmodule

// File: rtl/bf_twiddle_mul.sv
// Pipelined twiddle multiplier: out = in * (cos - j*sin), 3 enabled cycles, valid/ready.
// Define BF_TWIDDLE_ROUND_EN for round-half-up before the Q15 shift (default: truncate).
module bf_twiddle_mul
    import fft_pkg::*;
#(
    parameter int unsigned N     = 64,
    parameter int unsigned LOG2N = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CPLX_W-1:0] in_data,
    input  logic              in_first,
    input  logic [LOG2N-1:0]  in_stage,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CPLX_W-1:0] out_data,
    output logic [LOG2N-2:0]  out_tw_idx
);

    localparam int unsigned IW = LOG2N - 1;
    localparam int unsigned PW = 2 * DATA_W;
    localparam int unsigned FW = CPLX_W + 2;

    logic              en;
    logic              accept;
    logic [IW-1:0]     k_q, k_d, k_use, tw_idx;

    // Stage 1: sample, index, ROM output
    logic              v1_q;
    cplx_t             d1_q;
    logic [IW-1:0]     i1_q;
    logic signed [DATA_W-1:0] cos1, sin1;

    // Stage 2: partial products
    logic              v2_q;
    logic [IW-1:0]     i2_q;
    logic signed [PW-1:0] rc_d, is_d, ic_d, rs_d;
    logic signed [PW-1:0] rc_q, is_q, ic_q, rs_q;

    // Stage 3: result
    logic signed [FW-1:0] re_sum, im_sum, re_sh, im_sh;
    cplx_t             res_d;
    logic              out_valid_q;
    cplx_t             out_data_q;
    logic [IW-1:0]     out_idx_q;

    assign en         = !out_valid_q || out_ready;
    assign accept     = in_valid && en;
    assign in_ready   = en;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_tw_idx = out_idx_q;

    // (k mod (N >> (s+1))) << s is exactly k << s truncated to IW bits.
    always_comb begin
        k_use  = in_first ? '0 : k_q;
        tw_idx = k_use << in_stage;
        k_d    = accept ? k_use + IW'(1) : k_q;
    end

    bf_twiddle_rom #(
        .N     (N),
        .LOG2N (LOG2N)
    ) u_rom (
        .clk  (clk),
        .en   (en),
        .addr (tw_idx),
        .cos  (cos1),
        .sin  (sin1)
    );

    always_comb begin
        rc_d = PW'(cplx_re(d1_q)) * PW'(cos1);
        is_d = PW'(cplx_im(d1_q)) * PW'(sin1);
        ic_d = PW'(cplx_im(d1_q)) * PW'(cos1);
        rs_d = PW'(cplx_re(d1_q)) * PW'(sin1);
    end

    always_comb begin
        re_sum = FW'(rc_q) + FW'(is_q);
        im_sum = FW'(ic_q) - FW'(rs_q);
`ifdef BF_TWIDDLE_ROUND_EN
        re_sum = re_sum + (FW'(1) << (Q - 1));
        im_sum = im_sum + (FW'(1) << (Q - 1));
`endif
        re_sh  = re_sum >>> Q;
        im_sh  = im_sum >>> Q;
        res_d  = cplx_pack(sat16(re_sh), sat16(im_sh));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q         <= '0;
            v1_q        <= 1'b0;
            d1_q        <= '0;
            i1_q        <= '0;
            v2_q        <= 1'b0;
            i2_q        <= '0;
            rc_q        <= '0;
            is_q        <= '0;
            ic_q        <= '0;
            rs_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
        end else begin
            k_q <= k_d;
            if (en) begin
                v1_q        <= in_valid;
                d1_q        <= in_data;
                i1_q        <= tw_idx;
                v2_q        <= v1_q;
                i2_q        <= i1_q;
                rc_q        <= rc_d;
                is_q        <= is_d;
                ic_q        <= ic_d;
                rs_q        <= rs_d;
                out_valid_q <= v2_q;
                out_data_q  <= res_d;
                out_idx_q   <= i2_q;
            end
        end
    end

endmodule

// File: tb/tb_bf_twiddle_mul.sv
// Directed and randomized-backpressure bench for bf_twiddle_mul (N = 64).
module tb_bf_twiddle_mul;

    localparam int unsigned N     = 64;
    localparam int unsigned LOG2N = 6;
    localparam real         PI    = 3.14159265358979323846;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_first  = 1'b0;
    logic             out_ready = 1'b1;
    logic [31:0]      in_data   = '0;
    logic [LOG2N-1:0] in_stage  = '0;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_data;
    logic [LOG2N-2:0] out_tw_idx;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_d[$];
    logic [31:0] got_d[$];
    int          exp_i[$];
    int          got_i[$];
    int          km        = 0;
    bit          last_acc  = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] stall_data = '0;
    int          stall_err = 0;

    always #5 clk = ~clk;

    bf_twiddle_mul #(
        .N     (N),
        .LOG2N (LOG2N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_first   (in_first),
        .in_stage   (in_stage),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tw_idx (out_tw_idx)
    );

    function automatic longint tw(input int idx, input bit is_sin);
        real a;
        real v;
        a = 2.0 * PI * real'(idx) / real'(N);
        v = is_sin ? 32767.0 * $sin(a) : 32767.0 * $cos(a);
        if (v >= 0.0) return longint'($rtoi(v + 0.5));
        return -longint'($rtoi(0.5 - v));
    endfunction

    function automatic logic [15:0] clamp16(input longint v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic logic [31:0] model(input logic [31:0] d, input int idx);
        logic [15:0] d_re;
        logic [15:0] d_im;
        longint re, im, c, s, rf, jf;
        d_re = d[15:0];
        d_im = d[31:16];
        re = longint'($signed(d_re));
        im = longint'($signed(d_im));
        c  = tw(idx, 1'b0);
        s  = tw(idx, 1'b1);
        rf = re * c + im * s;
        jf = im * c - re * s;
`ifdef BF_TWIDDLE_ROUND_EN
        rf = rf + 16384;
        jf = jf + 16384;
`endif
        return {clamp16(jf >>> 15), clamp16(rf >>> 15)};
    endfunction

    task automatic clear_q();
        exp_d.delete();
        got_d.delete();
        exp_i.delete();
        got_i.delete();
    endtask

    // One clock: sample handshakes on the falling edge, return 1 unit after the rising edge.
    task automatic tick();
        int kk;
        int idx;
        @(negedge clk);
        if (stall_prev && (!out_valid || out_data !== stall_data)) stall_err++;
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_i.push_back(int'(out_tw_idx));
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            kk  = in_first ? 0 : km;
            idx = (kk << in_stage) % (N / 2);
            km  = (kk + 1) % (N / 2);
            exp_d.push_back(model(in_data, idx));
            exp_i.push_back(idx);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input bit first);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_first = first;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 200);
        n_checks++;
        if (!last_acc) begin
            n_fail++;
            $display("FAIL send_accept: not accepted after %0d cycles, required acceptance", n);
        end
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        n_checks++;
        if (out_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_out_data: got %h required 00000000", out_data);
        end
        n_checks++;
        if (out_tw_idx !== '0) begin
            n_fail++; $display("FAIL reset_tw_idx: got %0d required 0", out_tw_idx);
        end
    endtask

    task automatic test_basic();
        logic [31:0] req;
`ifdef BF_TWIDDLE_ROUND_EN
        req = 32'h0000_4000;
`else
        req = 32'h0000_3FFF;
`endif
        clear_q();
        out_ready = 1'b1;
        in_stage  = '0;
        in_valid  = 1'b1;
        in_first  = 1'b1;
        in_data   = 32'h0000_4000;
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
        n_checks++;
        if (last_acc !== 1'b1) begin
            n_fail++; $display("FAIL basic_accept: got %b required 1", last_acc);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_latency_early: out_valid got %b required 0", out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL basic_latency: out_valid got %b required 1", out_valid);
        end
        n_checks++;
        if (out_data !== req) begin
            n_fail++; $display("FAIL basic_data: got %h required %h", out_data, req);
        end
        n_checks++;
        if (out_tw_idx !== '0) begin
            n_fail++; $display("FAIL basic_idx: got %0d required 0", out_tw_idx);
        end
        drain();
    endtask

    task automatic test_minus_j();
        logic [31:0] req;
`ifdef BF_TWIDDLE_ROUND_EN
        req = 32'hC001_0000;
`else
        req = 32'hC000_0000;
`endif
        clear_q();
        in_stage = '0;
        send(32'h0, 1'b1);
        repeat (15) send(32'h0, 1'b0);
        send(32'h0000_4000, 1'b0);
        drain();
        n_checks++;
        if (got_d.size() != 17) begin
            n_fail++; $display("FAIL minus_j_count: got %0d required 17", got_d.size());
        end
        if (got_d.size() >= 17) begin
            n_checks++;
            if (got_d[16] !== req) begin
                n_fail++; $display("FAIL minus_j_data: got %h required %h", got_d[16], req);
            end
            n_checks++;
            if (got_i[16] != 16) begin
                n_fail++; $display("FAIL minus_j_idx: got %0d required 16", got_i[16]);
            end
        end
    endtask

    task automatic test_saturation();
        clear_q();
        in_stage = '0;
        send(32'h0, 1'b1);
        repeat (7) send(32'h0, 1'b0);
        send(32'h7FFF_7FFF, 1'b0);
        send(32'h0, 1'b1);
        repeat (7) send(32'h0, 1'b0);
        send(32'h8000_8000, 1'b0);
        drain();
        n_checks++;
        if (got_d.size() != 18) begin
            n_fail++; $display("FAIL sat_count: got %0d required 18", got_d.size());
        end
        if (got_d.size() >= 18) begin
            n_checks++;
            if (got_d[8] !== 32'h0000_7FFF) begin
                n_fail++; $display("FAIL sat_pos: got %h required 00007fff", got_d[8]);
            end
            n_checks++;
            if (got_i[8] != 8) begin
                n_fail++; $display("FAIL sat_idx: got %0d required 8", got_i[8]);
            end
            n_checks++;
            if (got_d[17] !== 32'h0000_8000) begin
                n_fail++; $display("FAIL sat_neg: got %h required 00008000", got_d[17]);
            end
        end
    endtask

    task automatic test_index_seq();
        clear_q();
        in_stage = 6'd2;
        for (int i = 0; i < 40; i++) begin
            send($urandom(), (i == 0) || (i == 32));
        end
        drain();
        n_checks++;
        if (got_d.size() != 40) begin
            n_fail++; $display("FAIL idx_count: got %0d required 40", got_d.size());
        end
        for (int i = 0; i < got_d.size() && i < 40; i++) begin
            n_checks++;
            if (got_i[i] != ((i % 32) % 8) * 4) begin
                n_fail++;
                $display("FAIL idx_seq[%0d]: got %0d required %0d", i, got_i[i], ((i % 32) % 8) * 4);
            end
            n_checks++;
            if (got_d[i] !== exp_d[i]) begin
                n_fail++; $display("FAIL idx_data[%0d]: got %h required %h", i, got_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int sent;
        int cyc;
        clear_q();
        stall_err = 0;
        sent = 0;
        cyc  = 0;
        in_valid = 1'b0;
        while (sent < 200 && cyc < 5000) begin
            out_ready = ($urandom_range(0, 1) == 1);
            if (!in_valid && $urandom_range(0, 9) < 7) begin
                in_valid = 1'b1;
                in_data  = $urandom();
                in_first = (sent == 0) || ($urandom_range(0, 19) == 0);
                if (in_first) in_stage = LOG2N'($urandom_range(0, LOG2N - 1));
            end
            tick();
            cyc++;
            if (last_acc) begin
                in_valid = 1'b0;
                in_first = 1'b0;
                sent++;
            end
        end
        drain();
        n_checks++;
        if (sent != 200) begin
            n_fail++; $display("FAIL bp_sent: got %0d required 200", sent);
        end
        n_checks++;
        if (got_d.size() != exp_d.size()) begin
            n_fail++; $display("FAIL bp_count: got %0d required %0d", got_d.size(), exp_d.size());
        end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_i[i] != exp_i[i]) begin
                n_fail++;
                $display("FAIL bp_item[%0d]: got %h/%0d required %h/%0d",
                         i, got_d[i], got_i[i], exp_d[i], exp_i[i]);
            end
        end
        n_checks++;
        if (stall_err != 0) begin
            n_fail++; $display("FAIL bp_stall_stable: got %0d changes required 0", stall_err);
        end
    endtask

    task automatic test_reset_midstream();
        int outs;
        clear_q();
        out_ready = 1'b1;
        in_stage  = '0;
        send(32'h1234_5678, 1'b1);
        send(32'h2345_6789, 1'b0);
        send(32'h3456_789A, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_out_valid: got %b required 0", out_valid);
        end
        n_checks++;
        if (out_data !== 32'h0 || out_tw_idx !== '0) begin
            n_fail++; $display("FAIL midrst_out_clear: got %h/%0d required 0/0", out_data, out_tw_idx);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        km = 0;
        stall_prev = 1'b0;
        clear_q();
        outs = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) outs++;
        end
        n_checks++;
        if (outs != 0 || got_d.size() != 0) begin
            n_fail++; $display("FAIL midrst_stale: got %0d outputs required 0", outs + got_d.size());
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_in_ready: got %b required 1", in_ready);
        end
        in_stage = 6'd1;
        send(32'h0000_4000, 1'b0);
        drain();
        n_checks++;
        if (got_d.size() != 1) begin
            n_fail++; $display("FAIL midrst_count: got %0d required 1", got_d.size());
        end
        if (got_d.size() >= 1) begin
            n_checks++;
            if (got_i[0] != 0) begin
                n_fail++; $display("FAIL midrst_k_cleared: got idx %0d required 0", got_i[0]);
            end
            n_checks++;
            if (got_d[0] !== exp_d[0]) begin
                n_fail++; $display("FAIL midrst_data: got %h required %h", got_d[0], exp_d[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_minus_j();
        test_saturation();
        test_index_seq();
        test_backpressure();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
